// File: rtl/udp_rx_stream_arb.sv
// rtl/udp_rx_stream_arb.sv - round-robin packet arbiter sharing one UDP RX header+data destination
//
// Grants one of NUM_SRC sources per packet and holds the grant until that
// packet's header and its last data beat have both been accepted downstream.
// Once a source is granted, both channels are muxed combinationally from it.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   src_hdr_val/src_hdr_rdy  per-source header handshake (a request is hdr_val)
//   src_src_ip, src_dst_ip   flattened per-source IPs, source i in slice i
//   src_udp_hdr              flattened udp_pkt_hdr {src_port, dst_port, length, checksum}
//   src_timestamp            flattened tracker_stats_struct
//   src_data_val/src_data_rdy per-source data handshake
//   src_data, src_last, src_padbytes  flattened per-source data beat fields
//   dst_hdr_*                muxed header channel to the destination
//   dst_data_*               muxed data channel to the destination

`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif

module udp_rx_stream_arb #(
    parameter int NUM_SRC         = 2,
    parameter int SRC_W           = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    parameter int UDP_HDR_W       = 64,
    parameter int TRACKER_STATS_W = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,

    input  logic [NUM_SRC-1:0]                   src_hdr_val,
    input  logic [NUM_SRC*`IP_ADDR_W-1:0]        src_src_ip,
    input  logic [NUM_SRC*`IP_ADDR_W-1:0]        src_dst_ip,
    input  logic [NUM_SRC*UDP_HDR_W-1:0]         src_udp_hdr,
    input  logic [NUM_SRC*TRACKER_STATS_W-1:0]   src_timestamp,
    output logic [NUM_SRC-1:0]                   src_hdr_rdy,

    input  logic [NUM_SRC-1:0]                   src_data_val,
    input  logic [NUM_SRC*`MAC_INTERFACE_W-1:0]  src_data,
    input  logic [NUM_SRC-1:0]                   src_last,
    input  logic [NUM_SRC*`MAC_PADBYTES_W-1:0]   src_padbytes,
    output logic [NUM_SRC-1:0]                   src_data_rdy,

    output logic                                 dst_hdr_val,
    output logic [`IP_ADDR_W-1:0]                dst_src_ip,
    output logic [`IP_ADDR_W-1:0]                dst_dst_ip,
    output logic [UDP_HDR_W-1:0]                 dst_udp_hdr,
    output logic [TRACKER_STATS_W-1:0]           dst_timestamp,
    input  logic                                 dst_hdr_rdy,

    output logic                                 dst_data_val,
    output logic [`MAC_INTERFACE_W-1:0]          dst_data,
    output logic                                 dst_last,
    output logic [`MAC_PADBYTES_W-1:0]           dst_padbytes,
    input  logic                                 dst_data_rdy
);

    // udp_pkt_hdr.length sits in bits [31:16]; a length equal to the bare
    // header size means the packet carries no payload beats at all.
    localparam int UDP_LEN_LSB   = 16;
    localparam int UDP_HDR_BYTES = 8;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state, state_n;
    logic [SRC_W-1:0] grant_reg, grant_n;
    logic [SRC_W-1:0] rr_ptr, rr_n;
    logic [SRC_W-1:0] grant_inc;
    logic [SRC_W-1:0] pick_idx;
    logic             pick_found;
    logic             hdr_done, hdr_done_n;
    logic             data_done, data_done_n;
    logic             hdr_hs, last_hs;
    int               cand;

    logic [`IP_ADDR_W-1:0]       src_ip_s  [NUM_SRC];
    logic [`IP_ADDR_W-1:0]       dst_ip_s  [NUM_SRC];
    logic [UDP_HDR_W-1:0]        udp_hdr_s [NUM_SRC];
    logic [TRACKER_STATS_W-1:0]  ts_s      [NUM_SRC];
    logic [`MAC_INTERFACE_W-1:0] data_s    [NUM_SRC];
    logic [`MAC_PADBYTES_W-1:0]  pad_s     [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_ip_s[i]  = src_src_ip[i*`IP_ADDR_W +: `IP_ADDR_W];
        assign dst_ip_s[i]  = src_dst_ip[i*`IP_ADDR_W +: `IP_ADDR_W];
        assign udp_hdr_s[i] = src_udp_hdr[i*UDP_HDR_W +: UDP_HDR_W];
        assign ts_s[i]      = src_timestamp[i*TRACKER_STATS_W +: TRACKER_STATS_W];
        assign data_s[i]    = src_data[i*`MAC_INTERFACE_W +: `MAC_INTERFACE_W];
        assign pad_s[i]     = src_padbytes[i*`MAC_PADBYTES_W +: `MAC_PADBYTES_W];
    end

    // Field muxes follow grant_reg in every state; in IDLE the valids are low,
    // so whatever source they show is don't-care (source 0 after reset).
    assign dst_src_ip    = src_ip_s[grant_reg];
    assign dst_dst_ip    = dst_ip_s[grant_reg];
    assign dst_udp_hdr   = udp_hdr_s[grant_reg];
    assign dst_timestamp = ts_s[grant_reg];
    assign dst_data      = data_s[grant_reg];
    assign dst_last      = src_last[grant_reg];
    assign dst_padbytes  = pad_s[grant_reg];

    assign grant_inc = (grant_reg == SRC_W'(NUM_SRC - 1)) ? '0 : grant_reg + 1'b1;

    // Round-robin pick: first header request at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = (32'(rr_ptr) + i) % NUM_SRC;
            if (!pick_found && src_hdr_val[SRC_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = SRC_W'(cand);
            end
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant_reg;
        rr_n         = rr_ptr;
        hdr_done_n   = hdr_done;
        data_done_n  = data_done;
        src_hdr_rdy  = '0;
        src_data_rdy = '0;
        dst_hdr_val  = 1'b0;
        dst_data_val = 1'b0;
        hdr_hs       = 1'b0;
        last_hs      = 1'b0;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n     = LOCKED;
                    grant_n     = pick_idx;
                    hdr_done_n  = 1'b0;
                    data_done_n = (udp_hdr_s[pick_idx][UDP_LEN_LSB +: 16] == 16'(UDP_HDR_BYTES));
                end
            end
            LOCKED: begin
                dst_hdr_val             = src_hdr_val[grant_reg] & ~hdr_done;
                src_hdr_rdy[grant_reg]  = dst_hdr_rdy & ~hdr_done;
                dst_data_val            = src_data_val[grant_reg] & ~data_done;
                src_data_rdy[grant_reg] = dst_data_rdy & ~data_done;

                hdr_hs  = src_hdr_val[grant_reg] & dst_hdr_rdy & ~hdr_done;
                last_hs = src_data_val[grant_reg] & dst_data_rdy & ~data_done & src_last[grant_reg];

                hdr_done_n  = hdr_done | hdr_hs;
                data_done_n = data_done | last_hs;

                // Release in the same cycle the second channel completes.
                if (hdr_done_n && data_done_n) begin
                    state_n     = IDLE;
                    rr_n        = grant_inc;
                    hdr_done_n  = 1'b0;
                    data_done_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_reg <= '0;
            rr_ptr    <= '0;
            hdr_done  <= 1'b0;
            data_done <= 1'b0;
        end else begin
            state     <= state_n;
            grant_reg <= grant_n;
            rr_ptr    <= rr_n;
            hdr_done  <= hdr_done_n;
            data_done <= data_done_n;
        end
    end

    a_one_rdy: assert property (@(posedge clk) disable iff (rst)
        $onehot0(src_hdr_rdy | src_data_rdy));
    a_idle_no_val: assert property (@(posedge clk) disable iff (rst)
        (state == IDLE) |-> (!dst_hdr_val && !dst_data_val));

endmodule

// File: tb/tb_udp_rx_stream_arb.sv
// tb/tb_udp_rx_stream_arb.sv - self-checking bench for udp_rx_stream_arb
module tb_udp_rx_stream_arb;

    localparam int N    = 4;
    localparam int IPW  = 32;
    localparam int DW   = 256;
    localparam int PW   = 5;
    localparam int HW   = 64;
    localparam int TW   = 64;
    localparam int MAXP = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]  hv, dv, lst;
    logic [IPW-1:0] sip [N];
    logic [IPW-1:0] dip [N];
    logic [HW-1:0]  uh  [N];
    logic [TW-1:0]  ts  [N];
    logic [DW-1:0]  dat [N];
    logic [PW-1:0]  pad [N];

    logic [N*IPW-1:0] src_src_ip, src_dst_ip;
    logic [N*HW-1:0]  src_udp_hdr;
    logic [N*TW-1:0]  src_timestamp;
    logic [N*DW-1:0]  src_data;
    logic [N*PW-1:0]  src_padbytes;
    logic [N-1:0]     src_hdr_rdy, src_data_rdy;

    logic            dst_hdr_val, dst_data_val, dst_last;
    logic [IPW-1:0]  dst_src_ip, dst_dst_ip;
    logic [HW-1:0]   dst_udp_hdr;
    logic [TW-1:0]   dst_timestamp;
    logic [DW-1:0]   dst_data;
    logic [PW-1:0]   dst_padbytes;
    logic            dst_hdr_rdy, dst_data_rdy;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign src_src_ip[g*IPW +: IPW]  = sip[g];
        assign src_dst_ip[g*IPW +: IPW]  = dip[g];
        assign src_udp_hdr[g*HW +: HW]   = uh[g];
        assign src_timestamp[g*TW +: TW] = ts[g];
        assign src_data[g*DW +: DW]      = dat[g];
        assign src_padbytes[g*PW +: PW]  = pad[g];
    end

    // Handshake summary: {dst_hdr_val, dst_data_val, src_hdr_rdy, src_data_rdy}
    wire [2*N+1:0] hs = {dst_hdr_val, dst_data_val, src_hdr_rdy, src_data_rdy};

    udp_rx_stream_arb #(.NUM_SRC(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .src_hdr_val   (hv),
        .src_src_ip    (src_src_ip),
        .src_dst_ip    (src_dst_ip),
        .src_udp_hdr   (src_udp_hdr),
        .src_timestamp (src_timestamp),
        .src_hdr_rdy   (src_hdr_rdy),
        .src_data_val  (dv),
        .src_data      (src_data),
        .src_last      (lst),
        .src_padbytes  (src_padbytes),
        .src_data_rdy  (src_data_rdy),
        .dst_hdr_val   (dst_hdr_val),
        .dst_src_ip    (dst_src_ip),
        .dst_dst_ip    (dst_dst_ip),
        .dst_udp_hdr   (dst_udp_hdr),
        .dst_timestamp (dst_timestamp),
        .dst_hdr_rdy   (dst_hdr_rdy),
        .dst_data_val  (dst_data_val),
        .dst_data      (dst_data),
        .dst_last      (dst_last),
        .dst_padbytes  (dst_padbytes),
        .dst_data_rdy  (dst_data_rdy)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [IPW-1:0] sip;
        logic [IPW-1:0] dip;
        logic [TW-1:0]  ts;
        int             id;
        int             nbeats;
        int             pd;
    } pkt_t;

    pkt_t pk [N][MAXP];
    int   npk [N];

    function automatic logic [DW-1:0] beat_data(int s, int id, int b);
        logic [31:0] w;
        w = {8'(s), 8'(id), 8'(b), 8'hA5};
        return {8{w}};
    endfunction

    function automatic logic [15:0] pkt_len(int nb, int pd);
        if (nb == 0) return 16'd8;
        return 16'(8 + nb * 32 - pd);
    endfunction

    function automatic logic [2*N+1:0] hs_exp(bit hval, bit dval, int hr_src, int dr_src);
        logic [N-1:0] hr, dr;
        hr = '0;
        dr = '0;
        if (hr_src >= 0) hr[hr_src] = 1'b1;
        if (dr_src >= 0) dr[dr_src] = 1'b1;
        return {hval, dval, hr, dr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hv = '0; dv = '0; lst = '0;
        dst_hdr_rdy = 1'b0; dst_data_rdy = 1'b0;
        for (int s = 0; s < N; s++) begin
            sip[s] = '0; dip[s] = '0; uh[s] = '0; ts[s] = '0; dat[s] = '0; pad[s] = '0;
        end
    endtask

    task automatic set_hdr(int s, logic [15:0] len);
        hv[s]  = 1'b1;
        sip[s] = 32'hC0A8_0100 + 32'(s);
        dip[s] = 32'h0A00_0000 + 32'(s);
        uh[s]  = {16'(1000 + s), 16'(2000 + s), len, 16'h1234};
        ts[s]  = 64'h1111_0000_0000_0000 + 64'(s);
    endtask

    task automatic set_beat(int s, int id, int b, bit is_last);
        dv[s]  = 1'b1;
        dat[s] = beat_data(s, id, b);
        lst[s] = is_last;
        pad[s] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        set_hdr(0, 16'd40);
        set_hdr(2, 16'd8);
        sip[0] = 32'hDEAD_0000;
        tick();
        tick();
        #1;
        checks++;
        if (hs !== '0) begin
            failures++; $display("FAIL reset_hs got=%b exp=%b", hs, {(2*N+2){1'b0}});
        end
        checks++;
        if (dst_src_ip !== 32'hDEAD_0000) begin
            failures++; $display("FAIL reset_mux_src0 got=%h exp=%h", dst_src_ip, 32'hDEAD_0000);
        end
        rst = 1'b0;
        hv  = '0;
        tick();
        #1;
        checks++;
        if (hs !== '0) begin
            failures++; $display("FAIL reset_after_hs got=%b exp=0", hs);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_hdr(0, 16'd40);
        set_beat(0, 1, 0, 1'b1);
        dst_hdr_rdy = 1'b1; dst_data_rdy = 1'b1;
        #1;
        checks++;
        if (hs !== '0) begin
            failures++; $display("FAIL single_c0 got=%b exp=0", hs);
        end
        tick(); #1;
        checks++;
        if (hs !== hs_exp(1, 1, 0, 0)) begin
            failures++; $display("FAIL single_c1_hs got=%b exp=%b", hs, hs_exp(1, 1, 0, 0));
        end
        checks++;
        if (dst_data !== beat_data(0, 1, 0) || dst_last !== 1'b1 || dst_udp_hdr[31:16] !== 16'd40) begin
            failures++; $display("FAIL single_c1_fields got=%h/%b/%0d exp=%h/1/40",
                                 dst_data[31:0], dst_last, dst_udp_hdr[31:16], beat_data(0, 1, 0) & 256'hFFFF_FFFF);
        end
        tick();
        dv = '0; lst = '0;
        set_hdr(0, 16'd8);
        set_hdr(1, 16'd8);
        #1;
        checks++;
        if (hs !== '0) begin
            failures++; $display("FAIL single_c2_idle got=%b exp=0", hs);
        end
        tick(); #1;
        checks++;
        if (hs !== hs_exp(1, 0, 1, -1)) begin
            failures++; $display("FAIL single_c3_rrptr got=%b exp=%b", hs, hs_exp(1, 0, 1, -1));
        end
    endtask

    task automatic test_zero_alt();
        int g;
        logic [2*N+1:0] e;
        do_reset();
        set_hdr(0, 16'd8);
        set_hdr(1, 16'd8);
        dst_hdr_rdy = 1'b1; dst_data_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            g = (k / 2) % 2;
            e = (k % 2 == 1) ? hs_exp(1, 0, g, -1) : '0;
            checks++;
            if (hs !== e) begin
                failures++; $display("FAIL zero_alt_c%0d got=%b exp=%b", k, hs, e);
            end
            if (k % 2 == 1) begin
                checks++;
                if (dst_src_ip !== 32'hC0A8_0100 + 32'(g)) begin
                    failures++; $display("FAIL zero_alt_ip_c%0d got=%h exp=%h", k, dst_src_ip, 32'hC0A8_0100 + 32'(g));
                end
            end
            tick();
        end
    endtask

    task automatic test_hold_hdr();
        logic [4:0] pat;
        int b;
        pat = 5'b10101;
        b = 0;
        do_reset();
        set_hdr(1, 16'd104);
        set_beat(1, 7, 0, 1'b0);
        dst_hdr_rdy = 1'b0; dst_data_rdy = 1'b1;
        #1;
        checks++;
        if (hs !== '0) begin
            failures++; $display("FAIL hold_c0 got=%b exp=0", hs);
        end
        tick();
        set_hdr(0, 16'd8);
        for (int c = 1; c <= 5; c++) begin
            dst_data_rdy = pat[c-1];
            set_beat(1, 7, b, b == 2);
            #1;
            checks++;
            if (hs !== hs_exp(1, 1, -1, pat[c-1] ? 1 : -1)) begin
                failures++; $display("FAIL hold_c%0d_hs got=%b exp=%b", c, hs, hs_exp(1, 1, -1, pat[c-1] ? 1 : -1));
            end
            checks++;
            if (dst_data !== beat_data(1, 7, b) || dst_last !== (b == 2)) begin
                failures++; $display("FAIL hold_c%0d_beat got=%h last=%b exp_beat=%0d", c, dst_data[31:0], dst_last, b);
            end
            if (pat[c-1]) b++;
            tick();
        end
        set_beat(1, 8, 0, 1'b0);
        dst_data_rdy = 1'b1;
        #1;
        checks++;
        if (hs !== hs_exp(1, 0, -1, -1)) begin
            failures++; $display("FAIL hold_c6 got=%b exp=%b", hs, hs_exp(1, 0, -1, -1));
        end
        tick();
        dst_hdr_rdy = 1'b1;
        #1;
        checks++;
        if (hs !== hs_exp(1, 0, 1, -1)) begin
            failures++; $display("FAIL hold_c7 got=%b exp=%b", hs, hs_exp(1, 0, 1, -1));
        end
        tick();
        hv[1] = 1'b0; dv[1] = 1'b0;
        #1;
        checks++;
        if (hs !== '0) begin
            failures++; $display("FAIL hold_c8 got=%b exp=0", hs);
        end
        tick(); #1;
        checks++;
        if (hs !== hs_exp(1, 0, 0, -1)) begin
            failures++; $display("FAIL hold_c9 got=%b exp=%b", hs, hs_exp(1, 0, 0, -1));
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        set_hdr(2, 16'd72);
        set_hdr(3, 16'd8);
        set_beat(2, 3, 0, 1'b0);
        dst_hdr_rdy = 1'b0; dst_data_rdy = 1'b1;
        #1;
        checks++;
        if (hs !== '0) begin
            failures++; $display("FAIL same_c0 got=%b exp=0", hs);
        end
        tick(); #1;
        checks++;
        if (hs !== hs_exp(1, 1, -1, 2)) begin
            failures++; $display("FAIL same_c1 got=%b exp=%b", hs, hs_exp(1, 1, -1, 2));
        end
        tick();
        set_beat(2, 3, 1, 1'b1);
        dst_hdr_rdy = 1'b1;
        #1;
        checks++;
        if (hs !== hs_exp(1, 1, 2, 2) || dst_last !== 1'b1) begin
            failures++; $display("FAIL same_c2 got=%b last=%b exp=%b last=1", hs, dst_last, hs_exp(1, 1, 2, 2));
        end
        tick();
        hv[2] = 1'b0; dv[2] = 1'b0; lst[2] = 1'b0;
        #1;
        checks++;
        if (hs !== '0) begin
            failures++; $display("FAIL same_c3 got=%b exp=0", hs);
        end
        tick(); #1;
        checks++;
        if (hs !== hs_exp(1, 0, 3, -1)) begin
            failures++; $display("FAIL same_c4 got=%b exp=%b", hs, hs_exp(1, 0, 3, -1));
        end
    endtask

    task automatic test_rr_skip();
        do_reset();
        set_hdr(1, 16'd8);
        dst_hdr_rdy = 1'b1; dst_data_rdy = 1'b1;
        tick(); #1;
        checks++;
        if (hs !== hs_exp(1, 0, 1, -1)) begin
            failures++; $display("FAIL rr_c1 got=%b exp=%b", hs, hs_exp(1, 0, 1, -1));
        end
        tick();
        set_hdr(3, 16'd8);
        #1;
        checks++;
        if (hs !== '0) begin
            failures++; $display("FAIL rr_c2 got=%b exp=0", hs);
        end
        tick(); #1;
        checks++;
        if (hs !== hs_exp(1, 0, 3, -1)) begin
            failures++; $display("FAIL rr_c3 got=%b exp=%b", hs, hs_exp(1, 0, 3, -1));
        end
        tick(); tick(); #1;
        checks++;
        if (hs !== hs_exp(1, 0, 1, -1)) begin
            failures++; $display("FAIL rr_c5 got=%b exp=%b", hs, hs_exp(1, 0, 1, -1));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_hdr(2, 16'd104);
        set_beat(2, 4, 0, 1'b0);
        dst_hdr_rdy = 1'b0; dst_data_rdy = 1'b1;
        tick(); #1;
        checks++;
        if (hs !== hs_exp(1, 1, -1, 2)) begin
            failures++; $display("FAIL rstmid_c1 got=%b exp=%b", hs, hs_exp(1, 1, -1, 2));
        end
        tick();
        set_beat(2, 4, 1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hv = '0; dv = '0;
        set_hdr(0, 16'd8);
        set_hdr(3, 16'd8);
        dst_hdr_rdy = 1'b1;
        #1;
        checks++;
        if (hs !== '0) begin
            failures++; $display("FAIL rstmid_idle got=%b exp=0", hs);
        end
        tick(); #1;
        checks++;
        if (hs !== hs_exp(1, 0, 0, -1)) begin
            failures++; $display("FAIL rstmid_rrptr got=%b exp=%b", hs, hs_exp(1, 0, 0, -1));
        end
    endtask

    // Packet-level reference: each source owns a list of packets; the model
    // hands the destination to one packet at a time and rotates a pointer.
    task automatic test_random();
        int  head [N];
        int  beat [N];
        bit  htaken [N];
        bit  raised [N];
        int  m_ptr, m_owner, delivered, total, cyc, c;
        bit  m_locked, m_hdone, m_ddone, exp_hv, exp_dv, found;
        logic [2*N+1:0] e;
        pkt_t p;

        do_reset();
        m_ptr = 0; m_owner = 0; m_locked = 0; m_hdone = 0; m_ddone = 0;
        delivered = 0; total = 0; cyc = 0;
        for (int s = 0; s < N; s++) begin
            head[s] = 0; beat[s] = 0; htaken[s] = 0; raised[s] = 0;
            npk[s] = $urandom_range(2, MAXP);
            total += npk[s];
            for (int q = 0; q < npk[s]; q++) begin
                pk[s][q].sip    = $urandom;
                pk[s][q].dip    = $urandom;
                pk[s][q].ts     = {$urandom, $urandom};
                pk[s][q].id     = s * 16 + q;
                pk[s][q].nbeats = $urandom_range(0, 4);
                pk[s][q].pd     = (pk[s][q].nbeats == 0) ? 0 : $urandom_range(0, 31);
            end
        end

        while (delivered < total && cyc < 20000) begin
            for (int s = 0; s < N; s++) begin
                hv[s] = 1'b0; dv[s] = 1'b0; lst[s] = 1'b0; dat[s] = '0; pad[s] = '0;
                if (head[s] < npk[s]) begin
                    p = pk[s][head[s]];
                    if (!htaken[s] && !raised[s] && $urandom_range(0, 3) != 0) raised[s] = 1;
                    hv[s]  = raised[s] && !htaken[s];
                    sip[s] = p.sip;
                    dip[s] = p.dip;
                    ts[s]  = p.ts;
                    uh[s]  = {16'(1000 + s), 16'(2000 + s), pkt_len(p.nbeats, p.pd), 16'(p.id)};
                    if (beat[s] < p.nbeats && $urandom_range(0, 4) != 0) begin
                        dv[s]  = 1'b1;
                        dat[s] = beat_data(s, p.id, beat[s]);
                        lst[s] = (beat[s] == p.nbeats - 1);
                        pad[s] = lst[s] ? PW'(p.pd) : '0;
                    end
                end
            end
            dst_hdr_rdy  = ($urandom_range(0, 2) != 0);
            dst_data_rdy = ($urandom_range(0, 2) != 0);
            #1;

            exp_hv = 0; exp_dv = 0; e = '0;
            if (m_locked) begin
                exp_hv = hv[m_owner] && !m_hdone;
                exp_dv = dv[m_owner] && !m_ddone;
                e = hs_exp(exp_hv, exp_dv,
                           (dst_hdr_rdy && !m_hdone) ? m_owner : -1,
                           (dst_data_rdy && !m_ddone) ? m_owner : -1);
            end
            checks++;
            if (hs !== e) begin
                failures++; $display("FAIL rand_hs cyc=%0d got=%b exp=%b", cyc, hs, e);
            end
            if (exp_hv) begin
                p = pk[m_owner][head[m_owner]];
                checks++;
                if (dst_src_ip !== p.sip || dst_dst_ip !== p.dip || dst_timestamp !== p.ts ||
                    dst_udp_hdr !== {16'(1000 + m_owner), 16'(2000 + m_owner), pkt_len(p.nbeats, p.pd), 16'(p.id)}) begin
                    failures++; $display("FAIL rand_hdr cyc=%0d got_ip=%h got_hdr=%h exp_ip=%h src=%0d",
                                         cyc, dst_src_ip, dst_udp_hdr, p.sip, m_owner);
                end
            end
            if (exp_dv) begin
                p = pk[m_owner][head[m_owner]];
                checks++;
                if (dst_data !== beat_data(m_owner, p.id, beat[m_owner]) ||
                    dst_last !== (beat[m_owner] == p.nbeats - 1) ||
                    dst_padbytes !== ((beat[m_owner] == p.nbeats - 1) ? PW'(p.pd) : PW'(0))) begin
                    failures++; $display("FAIL rand_data cyc=%0d got=%h last=%b pad=%0d exp_beat=%0d of %0d src=%0d",
                                         cyc, dst_data[31:0], dst_last, dst_padbytes, beat[m_owner], p.nbeats, m_owner);
                end
            end

            if (!m_locked) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (!found && hv[c]) begin
                        found = 1; m_locked = 1; m_owner = c; m_hdone = 0;
                        m_ddone = (pk[c][head[c]].nbeats == 0);
                    end
                end
            end else begin
                if (exp_hv && dst_hdr_rdy) begin
                    m_hdone = 1; htaken[m_owner] = 1;
                end
                if (exp_dv && dst_data_rdy) begin
                    beat[m_owner]++;
                    if (beat[m_owner] == pk[m_owner][head[m_owner]].nbeats) m_ddone = 1;
                end
                if (m_hdone && m_ddone) begin
                    m_locked = 0;
                    m_ptr = (m_owner + 1) % N;
                    head[m_owner]++;
                    beat[m_owner] = 0; htaken[m_owner] = 0; raised[m_owner] = 0;
                    delivered++;
                end
            end
            tick();
            cyc++;
        end
        checks++;
        if (delivered != total) begin
            failures++; $display("FAIL rand_drain delivered=%0d exp=%0d cycles=%0d", delivered, total, cyc);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_zero_alt();
        test_hold_hdr();
        test_same_cycle();
        test_rr_skip();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
